// File: rtl/idct4_da_if.sv
// Handshake and result bus of the 4-point DA inverse DCT.
// The producer side drives coefficients in; the DCT block answers with
// in_ready/busy and presents one reconstructed sample per out_valid pulse.
interface idct4_da_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 18
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic [1:0]              out_idx;
  logic                    out_last;
  logic                    busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/idct4_da.sv
// 4-point inverse DCT using bit-serial distributed arithmetic.
// Each cycle one bit-plane of the four stored coefficients addresses a
// constant table for the current output row; the table output is
// shift-accumulated LSB first, with the sign plane subtracted.
module idct4_da #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 18,
  parameter int FRAC  = 14
) (
  input logic        clk,
  input logic        rst,
  idct4_da_if.slave  bus
);

  typedef enum logic [1:0] {LOAD, COMPUTE, EMIT} state_t;

  // Q1.14 inverse DCT basis; row n builds sample y_n, column k weights X_k.
  localparam logic signed [15:0] COEF [4][4] = '{
    '{ 16'sd8192,  16'sd10703,  16'sd8192,  16'sd4433 },
    '{ 16'sd8192,  16'sd4433,  -16'sd8192, -16'sd10703 },
    '{ 16'sd8192, -16'sd4433,  -16'sd8192,  16'sd10703 },
    '{ 16'sd8192, -16'sd10703,  16'sd8192, -16'sd4433 }
  };

  state_t                  state;
  logic [1:0]              cnt;
  logic [1:0]              n;
  logic [3:0]              j;
  logic signed [31:0]      acc;
  logic signed [IN_W-1:0]  x [4];
  logic                    out_valid_r;
  logic signed [OUT_W-1:0] out_data_r;
  logic [1:0]              out_idx_r;
  logic                    out_last_r;

  logic [3:0]              plane;
  logic signed [15:0]      rom_data;
  logic signed [31:0]      rom_ext;
  logic signed [31:0]      addend;

  // Table lookup: sum the row-n constants of every coefficient whose bit j is set.
  always_comb begin
    plane    = '0;
    rom_data = '0;
    for (int k = 0; k < 4; k++) begin
      plane[k] = x[k][j];
      if (plane[k]) begin
        rom_data = rom_data + COEF[n][k];
      end
    end
    rom_ext = 32'(rom_data);
    addend  = rom_ext <<< j;
  end

  // Sequencer: load four words, run 16 planes per sample, emit, repeat for 4 samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      cnt         <= '0;
      n           <= '0;
      j           <= '0;
      acc         <= '0;
      for (int k = 0; k < 4; k++) begin
        x[k] <= '0;
      end
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_idx_r   <= '0;
      out_last_r  <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      case (state)
        LOAD: begin
          // in_ready is high throughout LOAD, so in_valid alone marks an accept.
          if (bus.in_valid) begin
            x[cnt] <= bus.in_data;
            cnt    <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state <= COMPUTE;
              n     <= '0;
              j     <= '0;
              acc   <= '0;
            end
          end
        end
        COMPUTE: begin
          if (j == 4'd15) begin
            acc   <= acc - addend;
            state <= EMIT;
          end else begin
            acc <= acc + addend;
          end
          j <= j + 4'd1;
        end
        EMIT: begin
          out_data_r  <= acc[FRAC +: OUT_W];
          out_idx_r   <= n;
          out_valid_r <= 1'b1;
          out_last_r  <= (n == 2'd3);
          acc         <= '0;
          if (n == 2'd3) begin
            state <= LOAD;
          end else begin
            n     <= n + 2'd1;
            state <= COMPUTE;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.busy      = (state != LOAD);
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_idct4_da.sv
// Scoreboard bench for idct4_da: blocks are issued with expected samples
// computed from the inverse DCT matrix; a monitor pops and compares on
// every out_valid pulse, including pulse timing relative to the 4th accept.
module tb_idct4_da;

  localparam int C [4][4] = '{
    '{ 8192,  10703,  8192,   4433 },
    '{ 8192,   4433, -8192, -10703 },
    '{ 8192,  -4433, -8192,  10703 },
    '{ 8192, -10703,  8192,  -4433 }
  };

  typedef struct {
    longint data;
    int     idx;
    bit     last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   e0_q[$];
  int   cur_e0 = -1000;
  exp_t mon_e;

  idct4_da_if bus ();

  idct4_da dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached, got cycle %0d, required finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: y_n = floor(sum_k C[n][k] * X_k / 2^14).
  function automatic longint refSample(input int n, input longint x0, input longint x1,
                                       input longint x2, input longint x3);
    longint s;
    s = C[n][0] * x0 + C[n][1] * x1 + C[n][2] * x2 + C[n][3] * x3;
    return s >>> 14;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"},  bus.in_ready,  1);
    checkOutput({tag, "_busy"},      bus.busy,      0);
    checkOutput({tag, "_out_valid"}, bus.out_valid, 0);
    checkOutput({tag, "_out_data"},  bus.out_data,  0);
    checkOutput({tag, "_out_idx"},   bus.out_idx,   0);
    checkOutput({tag, "_out_last"},  bus.out_last,  0);
  endtask

  task automatic sendWord(input logic signed [15:0] d, input int gap, output int acc_cyc);
    bit ready;
    int next_cyc;
    acc_cyc = -1;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 16'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 300; t++) begin
      ready    = bus.in_ready;
      next_cyc = cyc + 1;
      @(posedge clk);
      if (ready) begin
        acc_cyc = next_cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc_cyc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept of %0d, required accept within 300 cycles", d);
    end
  endtask

  task automatic applyStimulus(input logic signed [15:0] x0, input logic signed [15:0] x1,
                               input logic signed [15:0] x2, input logic signed [15:0] x3,
                               input int maxgap, input bit keep_valid,
                               output int first_acc, output int e0);
    exp_t e;
    int   a;
    for (int n = 0; n < 4; n++) begin
      e.data = refSample(n, x0, x1, x2, x3);
      e.idx  = n;
      e.last = (n == 3);
      exp_q.push_back(e);
    end
    sendWord(x0, $urandom_range(maxgap, 0), first_acc);
    sendWord(x1, $urandom_range(maxgap, 0), a);
    sendWord(x2, $urandom_range(maxgap, 0), a);
    sendWord(x3, $urandom_range(maxgap, 0), e0);
    e0_q.push_back(e0);
    if (!keep_valid) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: compare each output pulse against the scoreboard head.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got out_valid=1 idx=%0d data=%0d, required no pulse",
                 bus.out_idx, bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.idx == 0) begin
          cur_e0 = (e0_q.size() != 0) ? e0_q.pop_front() : -1000;
        end
        checkOutput("out_data",  bus.out_data, mon_e.data);
        checkOutput("out_idx",   bus.out_idx,  mon_e.idx);
        checkOutput("out_last",  bus.out_last, mon_e.last);
        checkOutput("pulse_cycle", cyc, cur_e0 + 17 * (mon_e.idx + 1));
        checkOutput("busy_at_pulse", bus.busy, (mon_e.idx != 3));
        checkOutput("in_ready_at_pulse", bus.in_ready, (mon_e.idx == 3));
      end
    end
  end

  initial begin
    int first_acc;
    int e0;
    int e0_prev;
    logic signed [15:0] r [4];

    // Reset with in_valid asserted: that word must not be stored.
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd999;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    checkResetState("reset");

    $display("[TB] directed blocks");
    applyStimulus(16'sd100, 16'sd0, 16'sd0, 16'sd0, 0, 1'b0, first_acc, e0);
    waitDrain();
    applyStimulus(16'sd0, 16'sd1000, 16'sd0, 16'sd0, 0, 1'b0, first_acc, e0);
    waitDrain();
    applyStimulus(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 0, 1'b0, first_acc, e0);
    waitDrain();
    applyStimulus(-16'sd32768, 16'sd0, 16'sd0, 16'sd0, 0, 1'b0, first_acc, e0);
    waitDrain();

    $display("[TB] in_valid held across two blocks");
    applyStimulus(16'sd1234, -16'sd567, 16'sd89, -16'sd3210, 0, 1'b1, first_acc, e0_prev);
    applyStimulus(16'sd10, 16'sd20, 16'sd30, 16'sd40, 0, 1'b0, first_acc, e0);
    checkOutput("second_block_first_accept", first_acc, e0_prev + 69);
    waitDrain();

    $display("[TB] reset during compute");
    applyStimulus(16'sd100, 16'sd0, 16'sd0, 16'sd0, 0, 1'b0, first_acc, e0);
    while (cyc < e0 + 29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    e0_q.delete();
    checkResetState("abort");
    repeat (60) @(negedge clk);
    applyStimulus(16'sd100, 16'sd0, 16'sd0, 16'sd0, 0, 1'b0, first_acc, e0);
    waitDrain();

    $display("[TB] random blocks with input gaps");
    applyStimulus(16'sd0, 16'sd1000, 16'sd0, 16'sd0, 3, 1'b0, first_acc, e0);
    waitDrain();
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 4; k++) r[k] = 16'($urandom);
      applyStimulus(r[0], r[1], r[2], r[3], 3, 1'b0, first_acc, e0);
      if (b % 2 == 1) waitDrain();
    end
    waitDrain();

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
